// File: rtl/sram_arbiter.sv
// Arbiter sharing one external SRAM between the recorder (writes) and the player (reads).
// Round-robin on contention, fixed-length access cycles, one turnaround cycle after every access.
//
// state   | meaning
// S_IDLE  | sample requests, grant one, latch its address/data
// S_WRITE | WE_N low, DQ driven, for WR_CYCLES cycles
// S_READ  | OE_N low for RD_CYCLES cycles, data captured on exit
// S_TURN  | bus turnaround; ack/valid pulse for the finished access
module sram_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_ack,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    output logic [DATA_W-1:0] o_SRAM_DQ,
    output logic              o_SRAM_DQ_OE,
    input  logic [DATA_W-1:0] i_SRAM_DQ,
    output logic              o_SRAM_WE_N,
    output logic              o_SRAM_OE_N,
    output logic              o_SRAM_CE_N,
    output logic              o_SRAM_UB_N,
    output logic              o_SRAM_LB_N
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_TURN} state_t;

    localparam logic [2:0] WR_LAST = 3'(WR_CYCLES - 1);
    localparam logic [2:0] RD_LAST = 3'(RD_CYCLES - 1);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic              r_last_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_dq;
    logic              r_dq_oe;
    logic              r_we_n;
    logic              r_oe_n;
    logic              r_wr_ack;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;

    logic w_grant_wr;
    logic w_grant_rd;

    // On a tie the side that did not win last time is granted.
    assign w_grant_wr = i_wr_req & (~i_rd_req | r_last_rd);
    assign w_grant_rd = i_rd_req & (~i_wr_req | ~r_last_rd);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= 3'd0;
            r_last_rd  <= 1'b1;
            r_addr     <= '0;
            r_dq       <= '0;
            r_dq_oe    <= 1'b0;
            r_we_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 3'd0;
                    if (w_grant_wr) begin
                        r_state   <= S_WRITE;
                        r_last_rd <= 1'b0;
                        r_addr    <= i_wr_addr;
                        r_dq      <= i_wr_data;
                        r_we_n    <= 1'b0;
                        r_dq_oe   <= 1'b1;
                    end else if (w_grant_rd) begin
                        r_state   <= S_READ;
                        r_last_rd <= 1'b1;
                        r_addr    <= i_rd_addr;
                        r_oe_n    <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (r_cnt == WR_LAST) begin
                        r_state  <= S_TURN;
                        r_cnt    <= 3'd0;
                        r_we_n   <= 1'b1;
                        r_dq_oe  <= 1'b0;
                        r_wr_ack <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_READ: begin
                    if (r_cnt == RD_LAST) begin
                        r_state    <= S_TURN;
                        r_cnt      <= 3'd0;
                        r_oe_n     <= 1'b1;
                        r_rd_data  <= i_SRAM_DQ;
                        r_rd_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_TURN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_wr_ack     = r_wr_ack;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = r_rd_data;
    assign o_busy       = (r_state != S_IDLE);
    assign o_SRAM_ADDR  = r_addr;
    assign o_SRAM_DQ    = r_dq;
    assign o_SRAM_DQ_OE = r_dq_oe;
    assign o_SRAM_WE_N  = r_we_n;
    assign o_SRAM_OE_N  = r_oe_n;
    assign o_SRAM_CE_N  = 1'b0;
    assign o_SRAM_UB_N  = 1'b0;
    assign o_SRAM_LB_N  = 1'b0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, single write/read, tie round-robin,
// post-grant input changes and reset in the middle of a write.
module tb_sram_arbiter;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 16;
    localparam int NWR    = 2;
    localparam int NRD    = 2;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_wr_req;
    logic [ADDR_W-1:0] i_wr_addr;
    logic [DATA_W-1:0] i_wr_data;
    logic              o_wr_ack;
    logic              i_rd_req;
    logic [ADDR_W-1:0] i_rd_addr;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_valid;
    logic              o_busy;
    logic [ADDR_W-1:0] o_SRAM_ADDR;
    logic [DATA_W-1:0] o_SRAM_DQ;
    logic              o_SRAM_DQ_OE;
    logic [DATA_W-1:0] i_SRAM_DQ;
    logic              o_SRAM_WE_N;
    logic              o_SRAM_OE_N;
    logic              o_SRAM_CE_N;
    logic              o_SRAM_UB_N;
    logic              o_SRAM_LB_N;

    logic [DATA_W-1:0] sram_val;
    int                n_checks;
    int                n_fails;

    sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYCLES(NWR), .RD_CYCLES(NRD)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_wr_req     (i_wr_req),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .o_wr_ack     (o_wr_ack),
        .i_rd_req     (i_rd_req),
        .i_rd_addr    (i_rd_addr),
        .o_rd_data    (o_rd_data),
        .o_rd_valid   (o_rd_valid),
        .o_busy       (o_busy),
        .o_SRAM_ADDR  (o_SRAM_ADDR),
        .o_SRAM_DQ    (o_SRAM_DQ),
        .o_SRAM_DQ_OE (o_SRAM_DQ_OE),
        .i_SRAM_DQ    (i_SRAM_DQ),
        .o_SRAM_WE_N  (o_SRAM_WE_N),
        .o_SRAM_OE_N  (o_SRAM_OE_N),
        .o_SRAM_CE_N  (o_SRAM_CE_N),
        .o_SRAM_UB_N  (o_SRAM_UB_N),
        .o_SRAM_LB_N  (o_SRAM_LB_N)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // SRAM drives the bus only while its output is enabled.
    assign i_SRAM_DQ = o_SRAM_OE_N ? 16'h0000 : sram_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge i_clk);
    endtask

    // Called at the negedge of the IDLE cycle in which the write is granted.
    task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                input bit change_after_grant);
        for (int i = 0; i < NWR; i++) begin
            @(negedge i_clk);
            chk("wr_we_n",  32'(o_SRAM_WE_N),  32'd0);
            chk("wr_oe_n",  32'(o_SRAM_OE_N),  32'd1);
            chk("wr_dq_oe", 32'(o_SRAM_DQ_OE), 32'd1);
            chk("wr_addr",  32'(o_SRAM_ADDR),  32'(a));
            chk("wr_dq",    32'(o_SRAM_DQ),    32'(d));
            chk("wr_ack_early", 32'(o_wr_ack), 32'd0);
            chk("wr_no_valid",  32'(o_rd_valid), 32'd0);
            chk("wr_busy",  32'(o_busy),       32'd1);
            if (change_after_grant && i == 0) begin
                i_wr_addr = ~a;
                i_wr_data = ~d;
            end
        end
        @(negedge i_clk);
        chk("turn_we_n",  32'(o_SRAM_WE_N),  32'd1);
        chk("turn_oe_n",  32'(o_SRAM_OE_N),  32'd1);
        chk("turn_dq_oe", 32'(o_SRAM_DQ_OE), 32'd0);
        chk("wr_ack",     32'(o_wr_ack),     32'd1);
        chk("turn_no_valid", 32'(o_rd_valid), 32'd0);
        i_wr_req = 1'b0;
        @(negedge i_clk);
        chk("wr_ack_pulse", 32'(o_wr_ack), 32'd0);
        chk("idle_busy",    32'(o_busy),   32'd0);
    endtask

    task automatic expect_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        for (int i = 0; i < NRD; i++) begin
            @(negedge i_clk);
            chk("rd_oe_n",  32'(o_SRAM_OE_N),  32'd0);
            chk("rd_we_n",  32'(o_SRAM_WE_N),  32'd1);
            chk("rd_dq_oe", 32'(o_SRAM_DQ_OE), 32'd0);
            chk("rd_addr",  32'(o_SRAM_ADDR),  32'(a));
            chk("rd_valid_early", 32'(o_rd_valid), 32'd0);
            chk("rd_no_ack", 32'(o_wr_ack), 32'd0);
        end
        @(negedge i_clk);
        chk("turn_oe_n", 32'(o_SRAM_OE_N), 32'd1);
        chk("rd_valid",  32'(o_rd_valid),  32'd1);
        chk("rd_data",   32'(o_rd_data),   32'(d));
        chk("turn_no_ack", 32'(o_wr_ack), 32'd0);
        i_rd_req = 1'b0;
        @(negedge i_clk);
        chk("rd_valid_pulse", 32'(o_rd_valid), 32'd0);
        chk("rd_data_hold",   32'(o_rd_data),  32'(d));
        chk("idle_busy",      32'(o_busy),     32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        sram_val  = 16'h0000;
        i_rst_n   = 1'b0;
        i_wr_req  = 1'b1;
        i_rd_req  = 1'b1;
        i_wr_addr = 20'h12345;
        i_wr_data = 16'hBEEF;
        i_rd_addr = 20'h54321;

        // Reset held 3 cycles with both requests high.
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            chk("rst_we_n",  32'(o_SRAM_WE_N),  32'd1);
            chk("rst_oe_n",  32'(o_SRAM_OE_N),  32'd1);
            chk("rst_ack",   32'(o_wr_ack),     32'd0);
            chk("rst_valid", 32'(o_rd_valid),   32'd0);
            chk("rst_busy",  32'(o_busy),       32'd0);
            chk("rst_dq_oe", 32'(o_SRAM_DQ_OE), 32'd0);
            chk("rst_addr",  32'(o_SRAM_ADDR),  32'd0);
            chk("rst_rdata", 32'(o_rd_data),    32'd0);
        end
        chk("ce_n", 32'({o_SRAM_CE_N, o_SRAM_UB_N, o_SRAM_LB_N}), 32'd0);
        i_rst_n  = 1'b1;
        i_wr_req = 1'b0;
        i_rd_req = 1'b0;
        idle_cycle();
        chk("idle_busy0", 32'(o_busy), 32'd0);

        // Single write.
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00010;
        i_wr_data = 16'hA5C3;
        expect_write(20'h00010, 16'hA5C3, 1'b0);

        // Single read at the top address.
        i_rd_req  = 1'b1;
        i_rd_addr = 20'hFFFFF;
        sram_val  = 16'h1234;
        expect_read(20'hFFFFF, 16'h1234);

        // Four back-to-back ties: W, R, W, R.
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00100;
        i_wr_data = 16'h1111;
        i_rd_req  = 1'b1;
        i_rd_addr = 20'h00200;
        sram_val  = 16'h2222;
        expect_write(20'h00100, 16'h1111, 1'b0);
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00300;
        i_wr_data = 16'h3333;
        expect_read(20'h00200, 16'h2222);
        i_rd_req  = 1'b1;
        i_rd_addr = 20'h00400;
        sram_val  = 16'h4444;
        expect_write(20'h00300, 16'h3333, 1'b0);
        expect_read(20'h00400, 16'h4444);

        // Inputs changed after grant must not reach the SRAM.
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h0ABCD;
        i_wr_data = 16'h5A5A;
        expect_write(20'h0ABCD, 16'h5A5A, 1'b1);

        // Reset during the 2nd write cycle aborts the access.
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00777;
        i_wr_data = 16'h7777;
        @(negedge i_clk);
        chk("ab_we_n1", 32'(o_SRAM_WE_N), 32'd0);
        @(negedge i_clk);
        chk("ab_we_n2", 32'(o_SRAM_WE_N), 32'd0);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        chk("ab_we_n_rst", 32'(o_SRAM_WE_N), 32'd1);
        chk("ab_no_ack",   32'(o_wr_ack),    32'd0);
        chk("ab_busy",     32'(o_busy),      32'd0);
        chk("ab_dq_oe",    32'(o_SRAM_DQ_OE), 32'd0);
        i_rst_n   = 1'b1;
        i_wr_req  = 1'b1;
        i_wr_addr = 20'h00888;
        i_wr_data = 16'h8888;
        i_rd_req  = 1'b1;
        i_rd_addr = 20'h00999;
        sram_val  = 16'h9999;
        expect_write(20'h00888, 16'h8888, 1'b0);
        expect_read(20'h00999, 16'h9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
